// File: rtl/pkt_cache_ctrl_if.sv
// Port bundle between the packet cache and its IBM / EBM / address-management peers.
// The cache uses the slave modport; the environment driving it uses master.
interface pkt_cache_ctrl_if #(
    parameter int DATA_W = 134,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] in_data;
    logic              in_data_wr;
    logic [ADDR_W-1:0] waddr;
    logic              waddr_wr;
    logic [ADDR_W-1:0] raddr;
    logic              raddr_wr;
    logic              in_ebm_alf;
    logic [DATA_W-1:0] out_data;
    logic              out_data_wr;
    logic              out_valid;
    logic              out_valid_wr;
    logic              wr_done_wr;
    logic [ADDR_W:0]   wr_len;
    logic              wr_err;
    logic              wr_busy;
    logic              rd_busy;

    modport master (
        output in_data, in_data_wr, waddr, waddr_wr, raddr, raddr_wr, in_ebm_alf,
        input  out_data, out_data_wr, out_valid, out_valid_wr,
        input  wr_done_wr, wr_len, wr_err, wr_busy, rd_busy
    );

    modport slave (
        input  in_data, in_data_wr, waddr, waddr_wr, raddr, raddr_wr, in_ebm_alf,
        output out_data, out_data_wr, out_valid, out_valid_wr,
        output wr_done_wr, wr_len, wr_err, wr_busy, rd_busy
    );
endinterface

// File: rtl/pkt_cache_ctrl.sv
// Packet cache: stores IBM cells into an internal simple-dual-port RAM and streams
// packets back to the EBM with back-pressure, length capping and completion reporting.
module pkt_cache_ctrl #(
    parameter int DATA_W    = 134,
    parameter int ADDR_W    = 11,
    parameter int RAM_LAT   = 2,
    parameter int MAX_CELLS = 32
) (
    input logic             clk,
    input logic             rst,
    pkt_cache_ctrl_if.slave bus
);
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [1:0]       TAG_TAIL = 2'b10;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CELLS);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_STORE, W_DROP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN}        rd_state_e;

    wr_state_e         wr_state_q;
    logic [ADDR_W-1:0] wr_base_q, ram_waddr_q;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, pend_len_q, wr_len_q;
    logic              ram_we_q, done_pend_q, pend_err_q, wr_done_q, wr_err_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              in_tail;

    rd_state_e         rd_state_q;
    logic [ADDR_W-1:0] rd_base_q, ram_raddr_q;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [RAM_LAT:0]  fly_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_pipe_q [RAM_LAT];
    logic [DATA_W-1:0] out_data_q, ret_data;
    logic              out_data_wr_q, out_valid_q, out_valid_wr_q;
    logic              ret_v, ret_tail, ret_last, issue;

    assign in_tail  = bus.in_data[DATA_W-1 -: 2] == TAG_TAIL;
    assign wr_cnt_d = wr_cnt_q + CNT_W'(1);

    // Done is reported one cycle after the tail, in step with its RAM commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q  <= W_IDLE;
            wr_base_q   <= '0;
            wr_cnt_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            done_pend_q <= 1'b0;
            pend_len_q  <= '0;
            pend_err_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_len_q    <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            ram_we_q    <= 1'b0;
            done_pend_q <= 1'b0;
            wr_done_q   <= done_pend_q;
            wr_len_q    <= done_pend_q ? pend_len_q : '0;
            wr_err_q    <= done_pend_q & pend_err_q;
            case (wr_state_q)
                W_IDLE: if (bus.waddr_wr) begin
                    wr_base_q  <= bus.waddr;
                    wr_state_q <= W_WAIT;
                end
                W_WAIT: if (bus.in_data_wr) begin
                    ram_we_q    <= 1'b1;
                    ram_waddr_q <= wr_base_q;
                    ram_wdata_q <= bus.in_data;
                    wr_cnt_q    <= CNT_W'(1);
                    if (in_tail) begin
                        done_pend_q <= 1'b1;
                        pend_len_q  <= CNT_W'(1);
                        pend_err_q  <= 1'b0;
                        wr_state_q  <= W_IDLE;
                    end else begin
                        wr_state_q <= W_STORE;
                    end
                end
                W_STORE: if (bus.in_data_wr) begin
                    ram_we_q    <= 1'b1;
                    ram_waddr_q <= wr_base_q + wr_cnt_q[ADDR_W-1:0];
                    ram_wdata_q <= bus.in_data;
                    wr_cnt_q    <= wr_cnt_d;
                    if (in_tail) begin
                        done_pend_q <= 1'b1;
                        pend_len_q  <= wr_cnt_d;
                        pend_err_q  <= 1'b0;
                        wr_state_q  <= W_IDLE;
                    end else if (wr_cnt_d == MAX_CNT) begin
                        wr_state_q <= W_DROP;
                    end
                end
                W_DROP: if (bus.in_data_wr && in_tail) begin
                    done_pend_q <= 1'b1;
                    pend_len_q  <= MAX_CNT;
                    pend_err_q  <= 1'b1;
                    wr_state_q  <= W_IDLE;
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // NOTE: the RAM and its read pipeline have no reset; stored packets survive rst
    // and stale pipeline data is never observed because fly_q qualifies it.
    // NOTE: non-blocking writes here make a same-edge read of the written address
    // return the previous contents (read-first).
    always_ff @(posedge clk) begin
        if (ram_we_q) mem[ram_waddr_q] <= ram_wdata_q;
        rd_pipe_q[0] <= mem[ram_raddr_q];
        for (int i = 1; i < RAM_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end

    assign ret_v    = fly_q[RAM_LAT];
    assign ret_data = rd_pipe_q[RAM_LAT-1];
    assign ret_tail = ret_v && (ret_data[DATA_W-1 -: 2] == TAG_TAIL);
    assign ret_last = (rd_state_q == R_DRAIN) && (fly_q[RAM_LAT-1:0] == '0);
    assign issue    = (rd_state_q == R_ISSUE) && !bus.in_ebm_alf && !ret_tail;
    assign rd_cnt_d = rd_cnt_q + CNT_W'(1);

    // A returning tail flushes every younger read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q     <= R_IDLE;
            rd_base_q      <= '0;
            rd_cnt_q       <= '0;
            ram_raddr_q    <= '0;
            fly_q          <= '0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
        end else begin
            out_data_wr_q  <= ret_v;
            out_data_q     <= ret_v ? ret_data : '0;
            out_valid_q    <= ret_v && (ret_tail || ret_last);
            out_valid_wr_q <= ret_v && (ret_tail || ret_last);
            fly_q          <= ret_tail ? '0 : {fly_q[RAM_LAT-1:0], issue};
            if (issue) begin
                ram_raddr_q <= rd_base_q + rd_cnt_q[ADDR_W-1:0];
                rd_cnt_q    <= rd_cnt_d;
            end
            case (rd_state_q)
                R_IDLE: if (bus.raddr_wr) begin
                    rd_base_q  <= bus.raddr;
                    rd_cnt_q   <= '0;
                    rd_state_q <= R_ISSUE;
                end
                R_ISSUE: if (ret_tail || (issue && rd_cnt_d == MAX_CNT)) rd_state_q <= R_DRAIN;
                R_DRAIN: if (fly_q == '0) rd_state_q <= R_IDLE;
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.out_data_wr  = out_data_wr_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_valid_wr = out_valid_wr_q;
    assign bus.wr_done_wr   = wr_done_q;
    assign bus.wr_len       = wr_len_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.wr_busy      = wr_state_q != W_IDLE;
    assign bus.rd_busy      = rd_state_q != R_IDLE;
endmodule

// File: tb/tb_pkt_cache_ctrl.sv
// Bench for pkt_cache_ctrl: a packet-level model (cell map plus expected output queues)
// checked every cycle, with literal expectations for lengths, error flags and cell counts.
module tb_pkt_cache_ctrl;
    localparam int DW = 134, AW = 11, LAT = 2, MAXC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_cache_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    pkt_cache_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(LAT), .MAX_CELLS(MAXC))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [DW-1:0] data; bit last; int due; } rd_exp_t;
    typedef struct { int len; bit err; int due; } wr_exp_t;

    rd_exp_t       exp_rd_q[$];
    wr_exp_t       exp_wr_q[$];
    logic [DW-1:0] mem_m [int];
    int            done_len_q[$];
    int            done_err_q[$];
    int            checks = 0, errors = 0, cyc = 0, rd_cells = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk_cell(input logic [1:0] tag, input int seed, input int i);
        logic [DW-3:0] body;
        body = {4'(i), 32'(seed), 32'(i * 7 + seed), 32'hC0DE_0000 + 32'(i), 32'(seed ^ i)};
        return {tag, body};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the first MAXC cells land at base+i (mod depth); done one cycle after the tail.
    task automatic send_pkt(input logic [AW-1:0] base, input int n, input int seed);
        logic [1:0]    tag;
        logic [AW-1:0] a;
        int            stored;
        stored = 0;
        bus.waddr = base;
        bus.waddr_wr = 1'b1;
        tick();
        bus.waddr_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            tag = (i == n - 1) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11);
            bus.in_data = mk_cell(tag, seed, i);
            bus.in_data_wr = 1'b1;
            if (i < MAXC) begin
                a = base + AW'(i);
                mem_m[int'(a)] = bus.in_data;
                stored++;
            end
            tick();
        end
        bus.in_data_wr = 1'b0;
        bus.in_data = '0;
        exp_wr_q.push_back('{len: stored, err: (n > MAXC), due: cyc + 1});
    endtask

    // Model: cells from base until a tail or MAXC cells; the last one carries out_valid.
    task automatic start_read(input logic [AW-1:0] base, input bit timed, output int t0);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            last;
        bus.raddr = base;
        bus.raddr_wr = 1'b1;
        tick();
        bus.raddr_wr = 1'b0;
        t0 = cyc;
        for (int i = 0; i < MAXC; i++) begin
            a = base + AW'(i);
            d = mem_m[int'(a)];
            last = (d[DW-1 -: 2] == 2'b10) || (i == MAXC - 1);
            exp_rd_q.push_back('{data: d, last: last, due: timed ? t0 + LAT + 2 + i : -1});
            if (last) break;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || bus.rd_busy || bus.wr_busy) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n < 300, 1);
        repeat (4) tick();
    endtask

    always @(negedge clk) begin : cmp
        rd_exp_t e;
        wr_exp_t w;
        if (!rst) begin
            if (bus.out_data_wr) begin
                rd_cells++;
                if (exp_rd_q.size() == 0) begin
                    check("rd_spurious", bus.out_data_wr, 0);
                end else begin
                    e = exp_rd_q.pop_front();
                    check("rd_data", bus.out_data, e.data);
                    check("rd_valid", {bus.out_valid, bus.out_valid_wr}, {e.last, e.last});
                    if (e.due >= 0) check("rd_time", cyc, e.due);
                end
            end else begin
                check("idle_data", bus.out_data, 0);
                check("idle_valid", {bus.out_valid, bus.out_valid_wr}, 0);
            end
            if (exp_wr_q.size() != 0 && exp_wr_q[0].due == cyc) begin
                w = exp_wr_q.pop_front();
                check("wr_done", bus.wr_done_wr, 1);
                check("wr_len", bus.wr_len, w.len);
                check("wr_err", bus.wr_err, w.err);
                done_len_q.push_back(int'(bus.wr_len));
                done_err_q.push_back(int'(bus.wr_err));
            end else begin
                check("wr_done_idle", bus.wr_done_wr, 0);
            end
        end
    end

    initial begin : main
        int t0, c;
        bus.in_data = '0;
        bus.in_data_wr = 1'b0;
        bus.waddr = '0;
        bus.waddr_wr = 1'b0;
        bus.raddr = '0;
        bus.raddr_wr = 1'b0;
        bus.in_ebm_alf = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_data_wr", bus.out_data_wr, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", {bus.out_valid, bus.out_valid_wr}, 0);
        check("rst_wr_done", {bus.wr_done_wr, bus.wr_err, bus.wr_len}, 0);
        check("rst_busy", {bus.wr_busy, bus.rd_busy}, 0);
        rst = 1'b0;
        tick();

        // 1: basic 4-cell packet, store then read back
        send_pkt(11'h010, 4, 1);
        wait_idle("t1_wr");
        check("t1_len_lit", done_len_q[$], 4);
        check("t1_err_lit", done_err_q[$], 0);
        rd_cells = 0;
        start_read(11'h010, 1'b1, t0);
        wait_idle("t1_rd");
        check("t1_cells_lit", rd_cells, 4);

        // 2: address wrap at top of RAM
        send_pkt(11'h7FE, 4, 2);
        wait_idle("t2_wr");
        rd_cells = 0;
        start_read(11'h7FE, 1'b1, t0);
        wait_idle("t2_rd");
        check("t2_cells_lit", rd_cells, 4);

        // 3: truncation, then a normal packet right after
        done_len_q.delete();
        done_err_q.delete();
        send_pkt(11'h300, 20, 3);
        send_pkt(11'h400, 3, 4);
        wait_idle("t3_wr");
        check("t3_done_cnt", done_len_q.size(), 2);
        if (done_len_q.size() == 2) begin
            check("t3_trunc_len_lit", done_len_q[0], 16);
            check("t3_trunc_err_lit", done_err_q[0], 1);
            check("t3_next_len_lit", done_len_q[1], 3);
            check("t3_next_err_lit", done_err_q[1], 0);
        end
        rd_cells = 0;
        start_read(11'h300, 1'b1, t0);
        wait_idle("t3_rd");
        check("t3_cap_cells_lit", rd_cells, 16);

        // 4: back-pressure after the third issue, held for five cycles
        send_pkt(11'h200, 10, 5);
        wait_idle("t4_wr");
        rd_cells = 0;
        start_read(11'h200, 1'b0, t0);
        repeat (3) tick();
        bus.in_ebm_alf = 1'b1;
        c = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_data_wr) c++;
        end
        bus.in_ebm_alf = 1'b0;
        check("t4_alf_burst", c <= LAT + 1, 1);
        c = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.out_data_wr) c++;
        end
        check("t4_quiet_after_alf", c, 0);
        wait_idle("t4_rd");
        check("t4_cells_lit", rd_cells, 10);

        // 5: read packet A while writing packet B
        send_pkt(11'h000, 6, 6);
        wait_idle("t5_wr_a");
        done_len_q.delete();
        done_err_q.delete();
        rd_cells = 0;
        fork
            start_read(11'h000, 1'b1, t0);
            send_pkt(11'h100, 5, 7);
        join
        wait_idle("t5_conc");
        check("t5_cells_lit", rd_cells, 6);
        check("t5_len_lit", done_len_q.size() == 1 && done_len_q[0] == 5, 1);
        rd_cells = 0;
        start_read(11'h100, 1'b1, t0);
        wait_idle("t5_rd_b");
        check("t5_b_cells_lit", rd_cells, 5);

        // 6: reset while the third cell is on the output
        start_read(11'h000, 1'b1, t0);
        c = 0;
        while (cyc < t0 + LAT + 4 && c < 20) begin
            tick();
            c++;
        end
        check("t6_third_cell_out", bus.out_data_wr, 1);
        rst = 1'b1;
        #1;
        exp_rd_q.delete();
        check("t6_rst_data", {bus.out_data_wr, bus.out_data}, 0);
        check("t6_rst_valid", {bus.out_valid, bus.out_valid_wr, bus.wr_done_wr}, 0);
        check("t6_rst_busy", {bus.wr_busy, bus.rd_busy}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rd_cells = 0;
        start_read(11'h000, 1'b1, t0);
        wait_idle("t6_rd");
        check("t6_cells_lit", rd_cells, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
